mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Load/store controller sitting directly upstream of the data RAM; it is the only block that drives the RAM's address, read, write, byte-search and write-data pins.
- Accepts one memory request at a time from the execute stage over a valid/ready handshake.
- Sequences word loads, byte loads (zero- or sign-extended) and byte stores. Byte stores are done as read-modify-write, because the RAM writes whole words only.
- Returns a registered one-cycle response to the writeback stage.

Parameters:
- DEPTH_BITS, 8, log2 of the RAM word count (256 words); word index >= 2**DEPTH_BITS is out of range.
- DATA_W, 16, RAM word width; byte lanes are [DATA_W-1:8] (high) and [7:0] (low).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  block can accept; request transfers when ReqValid & ReqReady at a rising edge.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqByte  in  1  1 = byte access (ReqAddr is a byte address), 0 = word access (ReqAddr is a word index).
- ReqSigned  in  1  byte loads only: 1 = sign-extend bit 7, 0 = zero-extend.
- ReqAddr  in  16  request address.
- ReqData  in  16  store data; byte stores use [7:0].
- RespValid  out  1  one-cycle pulse; response fields valid.
- RespData  out  16  load result; 0 for stores and errors.
- RespErr  out  1  address out of range; no RAM access was made.
- RamAddress  out  16  RAM read address (word index, or byte address when RamSearch=1).
- RamWriteAddr  out  16  RAM write word index.
- RamRead  out  1  RAM read enable.
- RamWrite  out  1  RAM write enable; level-sensitive at the RAM, so held for exactly one cycle.
- RamSearch  out  1  RAM byte-read mode: RAM returns the zero-extended byte; addr[0]=0 selects high byte, addr[0]=1 selects low byte.
- RamDataIn  out  16  write data to RAM.
- RamDataOut  in  16  RAM combinational read data.

Behaviour:
- Reset values:
  - State = IDLE.
  - ReqReady=0 during the reset cycle, 1 on the first cycle after RST deasserts.
  - RespValid=0, RespData=0, RespErr=0.
  - All Ram* outputs = 0.
- ReqReady = (state==IDLE) & ~RST. ReqValid in any other state is ignored; the requester must hold it.
- On acceptance, latch ReqWrite, ReqByte, ReqSigned, ReqAddr and ReqData; later changes on the inputs have no effect.
- Word index:
  - Word access: ReqAddr.
  - Byte access: ReqAddr >> 1.
  - Out of range if word index >= 2**DEPTH_BITS.
- States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- IDLE on accept:
  - Out of range -> RESP with err set.
  - Load -> RD.
  - Word store -> WR.
  - Byte store -> RMW_RD.
- RD, one cycle:
  - RamRead=1.
  - Byte load: RamSearch=1, RamAddress = byte address.
  - Word load: RamSearch=0, RamAddress = word index.
  - Capture RamDataOut at the edge. For byte loads, extend bit 7 if ReqSigned, and force [15:8]=0 otherwise.
  - -> RESP.
- WR, one cycle: RamWrite=1, RamWriteAddr = word index, RamDataIn = ReqData. -> RESP.
- RMW_RD, one cycle:
  - RamRead=1, RamSearch=0, RamAddress = word index.
  - Capture the word.
  - Merge ReqData[7:0] into the high lane if addr[0]=0, or the low lane if addr[0]=1.
  - -> RMW_WR.
- RMW_WR, one cycle: RamWrite=1 with the merged word. -> RESP.
- RESP, one cycle: RespValid=1 with registered RespData and RespErr. -> IDLE.
- Outside RESP, RespValid=0; RespData and RespErr hold their last values.
- Latency from the acceptance edge to RespValid:
  - Load and word store: 2 cycles.
  - Byte store: 3 cycles.
  - Error: 1 cycle.
- Throughput: next accept is possible on the cycle after RESP.
- Ram* outputs are decoded from state and gated with ~RST. Outside the states that drive them, the strobes are 0 and the address/data outputs are 0.
- RST mid-operation:
  - The strobes drop in the same cycle, so RST high during WR or RMW_WR performs no write.
  - State returns to IDLE at the edge.
  - No RespValid is produced for the abandoned request.
- Word index 2**DEPTH_BITS-1 is valid; 2**DEPTH_BITS raises the error. For byte access the checked index is ReqAddr[15:1].

Test Plan:
- Word store ReqAddr=0x0005, ReqData=0xABCD -> RamWrite high exactly 1 cycle with RamWriteAddr=0x0005, RamDataIn=0xABCD; RespValid 2 cycles after accept, RespData=0. Then word load 0x0005 -> RespData=0xABCD.
- Byte store ReqByte=1, ReqAddr=0x000B, ReqData=0x0012 after the above -> RMW_RD reads 0xABCD, RMW_WR writes 0xAB12; RespValid 3 cycles after accept. Word load 0x0005 -> 0xAB12.
- Byte load 0x000A, ReqSigned=0 -> RamSearch=1, RamAddress=0x000A, RespData=0x00AB. Repeat with ReqSigned=1 -> 0xFFAB. Byte load 0x000B signed -> 0x0012.
- Word load ReqAddr=0x0100 and byte load 0x0200 -> RespErr=1, RespData=0, RespValid 1 cycle after accept; RamRead/RamWrite never asserted. Word load 0x00FF -> RespErr=0.
- RST asserted during the RMW_WR cycle of a byte store of 0x0077 to 0x000A -> RamWrite=0 that cycle, no RespValid, ReqReady=1 the cycle after RST falls; word 5 still reads 0xAB12.
- ReqValid held high with changing ReqAddr while busy -> only the accept-edge request is executed; ReqReady=0 from RD through RESP; back-to-back requests accepted every 3 cycles for loads.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer in front of a word-wide data RAM: word loads, byte loads with
// optional sign extension, and byte stores done as read-modify-write.
module mem_access_ctrl #(
   parameter int unsigned DEPTH_BITS = 8,
   parameter int unsigned DATA_W     = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic              ReqWrite,
   input  logic              ReqByte,
   input  logic              ReqSigned,
   input  logic [15:0]       ReqAddr,
   input  logic [DATA_W-1:0] ReqData,
   output logic              RespValid,
   output logic [DATA_W-1:0] RespData,
   output logic              RespErr,
   output logic [15:0]       RamAddress,
   output logic [15:0]       RamWriteAddr,
   output logic              RamRead,
   output logic              RamWrite,
   output logic              RamSearch,
   output logic [DATA_W-1:0] RamDataIn,
   input  logic [DATA_W-1:0] RamDataOut
);

   typedef enum logic [2:0] {StIdle, StRd, StWr, StRmwRd, StRmwWr, StResp} state_e;

   state_e            stateQ, stateD;
   logic              byteQ, signedQ, respErrQ;
   logic [15:0]       addrQ;
   logic [DATA_W-1:0] dataQ, mergeQ, respDataQ;

   logic [15:0]       reqIdx, curIdx;
   logic              reqOor, accept;
   logic [DATA_W-1:0] loadVal, mergeVal;

   // Byte addresses map to word index addr>>1; range check is on the word index.
   assign reqIdx = ReqByte ? {1'b0, ReqAddr[15:1]} : ReqAddr;
   assign curIdx = byteQ ? {1'b0, addrQ[15:1]} : addrQ;
   assign reqOor = (reqIdx >> DEPTH_BITS) != 16'd0;

   assign ReqReady  = (stateQ == StIdle) && !RST;
   assign accept    = ReqValid && ReqReady;
   assign RespValid = (stateQ == StResp) && !RST;
   assign RespData  = respDataQ;
   assign RespErr   = respErrQ;

   always_comb begin
      loadVal  = RamDataOut;
      mergeVal = RamDataOut;
      if (byteQ) begin
         loadVal = {{(DATA_W-8){signedQ & RamDataOut[7]}}, RamDataOut[7:0]};
      end
      // addr[0]=0 addresses the high lane, addr[0]=1 the low lane
      if (addrQ[0]) begin
         mergeVal[7:0] = dataQ[7:0];
      end else begin
         mergeVal[DATA_W-1:8] = (DATA_W-8)'(dataQ[7:0]);
      end
   end

   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         StIdle: begin
            if (accept) begin
               if (reqOor)         stateD = StResp;
               else if (!ReqWrite) stateD = StRd;
               else if (ReqByte)   stateD = StRmwRd;
               else                stateD = StWr;
            end
         end
         StRd, StWr, StRmwWr: stateD = StResp;
         StRmwRd:             stateD = StRmwWr;
         StResp:              stateD = StIdle;
         default:             stateD = StIdle;
      endcase
   end

   // RAM pins decode from state; reset kills the strobes in the same cycle.
   always_comb begin
      RamAddress   = '0;
      RamWriteAddr = '0;
      RamRead      = 1'b0;
      RamWrite     = 1'b0;
      RamSearch    = 1'b0;
      RamDataIn    = '0;
      if (!RST) begin
         unique case (stateQ)
            StRd: begin
               RamRead    = 1'b1;
               RamSearch  = byteQ;
               RamAddress = byteQ ? addrQ : curIdx;
            end
            StRmwRd: begin
               RamRead    = 1'b1;
               RamAddress = curIdx;
            end
            StWr: begin
               RamWrite     = 1'b1;
               RamWriteAddr = curIdx;
               RamDataIn    = dataQ;
            end
            StRmwWr: begin
               RamWrite     = 1'b1;
               RamWriteAddr = curIdx;
               RamDataIn    = mergeQ;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         stateQ    <= StIdle;
         byteQ     <= 1'b0;
         signedQ   <= 1'b0;
         addrQ     <= '0;
         dataQ     <= '0;
         mergeQ    <= '0;
         respDataQ <= '0;
         respErrQ  <= 1'b0;
      end else begin
         stateQ <= stateD;
         if (accept) begin
            byteQ   <= ReqByte;
            signedQ <= ReqSigned;
            addrQ   <= ReqAddr;
            dataQ   <= ReqData;
            if (reqOor) begin
               respDataQ <= '0;
               respErrQ  <= 1'b1;
            end
         end
         unique case (stateQ)
            StRd: begin
               respDataQ <= loadVal;
               respErrQ  <= 1'b0;
            end
            StRmwRd: mergeQ <= mergeVal;
            StWr, StRmwWr: begin
               respDataQ <= '0;
               respErrQ  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: RAM model, shadow-memory reference, directed steps then
// random traffic.
module tb_mem_access_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ReqValid, ReqReady, ReqWrite, ReqByte, ReqSigned;
   logic [15:0] ReqAddr, ReqData;
   logic        RespValid, RespErr;
   logic [15:0] RespData;
   logic [15:0] RamAddress, RamWriteAddr, RamDataIn, RamDataOut;
   logic        RamRead, RamWrite, RamSearch;

   logic [15:0] ram    [0:255];
   logic [15:0] refMem [0:255];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int rdCnt  = 0;
   int wrCnt  = 0;
   int accCyc = 0;
   int prevAcc = 0;
   logic [15:0] lastRdAddr, lastWrAddr, lastWrData;
   logic        lastRdSearch;

   mem_access_ctrl #(.DEPTH_BITS(8), .DATA_W(16)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .ReqValid     (ReqValid),
      .ReqReady     (ReqReady),
      .ReqWrite     (ReqWrite),
      .ReqByte      (ReqByte),
      .ReqSigned    (ReqSigned),
      .ReqAddr      (ReqAddr),
      .ReqData      (ReqData),
      .RespValid    (RespValid),
      .RespData     (RespData),
      .RespErr      (RespErr),
      .RamAddress   (RamAddress),
      .RamWriteAddr (RamWriteAddr),
      .RamRead      (RamRead),
      .RamWrite     (RamWrite),
      .RamSearch    (RamSearch),
      .RamDataIn    (RamDataIn),
      .RamDataOut   (RamDataOut)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Combinational-read RAM with byte-search mode
   always_comb begin
      if (RamSearch) begin
         if (RamAddress[0]) RamDataOut = {8'h00, ram[RamAddress[8:1]][7:0]};
         else               RamDataOut = {8'h00, ram[RamAddress[8:1]][15:8]};
      end else begin
         RamDataOut = ram[RamAddress[7:0]];
      end
   end

   always @(negedge CLK) begin
      if (RamWrite) begin
         ram[RamWriteAddr[7:0]] <= RamDataIn;
         wrCnt      <= wrCnt + 1;
         lastWrAddr <= RamWriteAddr;
         lastWrData <= RamDataIn;
      end
      if (RamRead) begin
         rdCnt        <= rdCnt + 1;
         lastRdAddr   <= RamAddress;
         lastRdSearch <= RamSearch;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request (starting at a negedge) and check its complete effect.
   task automatic doReq(input logic w, input logic b, input logic s, input logic [15:0] a,
                        input logic [15:0] d, input logic holdValid);
      logic [15:0] idx, expData, expWr;
      logic [7:0]  byteV;
      logic        err, busyBad;
      int          expLat, expRd, expWrN, lat, rd0, wr0, waitN;
      idx     = b ? {1'b0, a[15:1]} : a;
      err     = idx >= 16'd256;
      expData = 16'h0000;
      expWr   = 16'h0000;
      expLat  = err ? 1 : (w && b) ? 3 : 2;
      expRd   = (!err && (!w || b)) ? 1 : 0;
      expWrN  = (!err && w) ? 1 : 0;
      if (!err) begin
         if (!w) begin
            if (b) begin
               byteV   = a[0] ? refMem[idx[7:0]][7:0] : refMem[idx[7:0]][15:8];
               expData = {(s && byteV[7]) ? 8'hFF : 8'h00, byteV};
            end else begin
               expData = refMem[idx[7:0]];
            end
         end else begin
            expWr = refMem[idx[7:0]];
            if (!b)       expWr = d;
            else if (a[0]) expWr[7:0] = d[7:0];
            else          expWr[15:8] = d[7:0];
            refMem[idx[7:0]] = expWr;
         end
      end
      ReqValid  = 1'b1;
      ReqWrite  = w;
      ReqByte   = b;
      ReqSigned = s;
      ReqAddr   = a;
      ReqData   = d;
      waitN = 0;
      while (ReqReady !== 1'b1 && waitN < 20) begin
         @(negedge CLK);
         waitN++;
      end
      if (ReqReady !== 1'b1) begin
         check("accept_timeout", 32'(ReqReady), 32'd1);
         ReqValid = 1'b0;
         return;
      end
      rd0     = rdCnt;
      wr0     = wrCnt;
      prevAcc = accCyc;
      accCyc  = cyc;
      @(posedge CLK);
      lat     = 0;
      busyBad = 1'b0;
      for (int k = 1; k <= 6 && lat == 0; k++) begin
         @(negedge CLK);
         if (k == 1) begin
            ReqAddr   = 16'($urandom);
            ReqData   = 16'($urandom);
            ReqWrite  = 1'($urandom);
            ReqByte   = 1'($urandom);
            ReqSigned = 1'($urandom);
            ReqValid  = holdValid;
         end
         if (ReqReady !== 1'b0) busyBad = 1'b1;
         if (RespValid === 1'b1) lat = k;
      end
      ReqValid = 1'b0;
      check("latency", 32'(lat), 32'(expLat));
      check("resp_err", 32'(RespErr), 32'(err));
      check("resp_data", 32'(RespData), 32'(expData));
      check("ready_low_busy", 32'(busyBad), 32'd0);
      check("ram_read_count", 32'(rdCnt - rd0), 32'(expRd));
      check("ram_write_count", 32'(wrCnt - wr0), 32'(expWrN));
      if (expRd == 1) begin
         check("ram_read_addr", 32'(lastRdAddr), 32'((!w && b) ? a : idx));
         check("ram_search", 32'(lastRdSearch), 32'(!w && b));
      end
      if (expWrN == 1) begin
         check("ram_write_addr", 32'(lastWrAddr), 32'(idx));
         check("ram_write_data", 32'(lastWrData), 32'(expWr));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ra, rv;
      logic        rw, rb, rs, rh;
      int          wr0, mism, waitN, seenResp;
      for (int i = 0; i < 256; i++) begin
         rv        = 16'($urandom);
         ram[i]    = rv;
         refMem[i] = rv;
      end
      RST       = 1'b1;
      ReqValid  = 1'b0;
      ReqWrite  = 1'b0;
      ReqByte   = 1'b0;
      ReqSigned = 1'b0;
      ReqAddr   = 16'h0000;
      ReqData   = 16'h0000;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_ready", 32'(ReqReady), 32'd0);
      check("rst_resp_valid", 32'(RespValid), 32'd0);
      check("rst_resp_data", 32'(RespData), 32'd0);
      check("rst_resp_err", 32'(RespErr), 32'd0);
      check("rst_ram_strobes", 32'({RamRead, RamWrite, RamSearch}), 32'd0);
      check("rst_ram_buses", 32'({RamAddress | RamWriteAddr | RamDataIn}), 32'd0);
      RST = 1'b0;
      @(negedge CLK);
      check("ready_after_rst", 32'(ReqReady), 32'd1);

      // Word store / load, then byte-store RMW
      doReq(1'b1, 1'b0, 1'b0, 16'h0005, 16'hABCD, 1'b0);
      doReq(1'b0, 1'b0, 1'b0, 16'h0005, 16'h0000, 1'b0);
      check("tp_word_load", 32'(RespData), 32'h0000ABCD);
      doReq(1'b1, 1'b1, 1'b0, 16'h000B, 16'h0012, 1'b0);
      doReq(1'b0, 1'b0, 1'b0, 16'h0005, 16'h0000, 1'b1);
      check("tp_rmw_result", 32'(RespData), 32'h0000AB12);

      // Back-to-back byte loads with ReqValid held and inputs changing while busy
      doReq(1'b0, 1'b1, 1'b0, 16'h000A, 16'h0000, 1'b1);
      check("b2b_interval_1", 32'(accCyc - prevAcc), 32'd3);
      doReq(1'b0, 1'b1, 1'b1, 16'h000A, 16'h0000, 1'b1);
      check("b2b_interval_2", 32'(accCyc - prevAcc), 32'd3);
      check("tp_signed_byte", 32'(RespData), 32'h0000FFAB);
      doReq(1'b0, 1'b1, 1'b1, 16'h000B, 16'h0000, 1'b0);

      // Range boundaries
      doReq(1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, 1'b0);
      doReq(1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0);
      doReq(1'b1, 1'b0, 1'b0, 16'h0100, 16'h1234, 1'b0);
      doReq(1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0000, 1'b0);
      doReq(1'b0, 1'b1, 1'b0, 16'h01FF, 16'h0000, 1'b0);

      // Reset during the RMW write cycle of a byte store
      ReqValid  = 1'b1;
      ReqWrite  = 1'b1;
      ReqByte   = 1'b1;
      ReqSigned = 1'b0;
      ReqAddr   = 16'h000A;
      ReqData   = 16'h0077;
      waitN = 0;
      while (ReqReady !== 1'b1 && waitN < 20) begin
         @(negedge CLK);
         waitN++;
      end
      wr0 = wrCnt;
      @(posedge CLK);
      ReqValid = 1'b0;
      @(posedge CLK);
      #1 RST = 1'b1;
      @(negedge CLK);
      check("rst_mid_no_write", 32'(RamWrite), 32'd0);
      check("rst_mid_no_resp", 32'(RespValid), 32'd0);
      check("rst_mid_ready", 32'(ReqReady), 32'd0);
      @(posedge CLK);
      #1 RST = 1'b0;
      seenResp = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         if (k == 0) check("rst_mid_ready_after", 32'(ReqReady), 32'd1);
         if (RespValid === 1'b1) seenResp++;
      end
      check("rst_mid_resp_count", 32'(seenResp), 32'd0);
      check("rst_mid_write_count", 32'(wrCnt - wr0), 32'd0);
      doReq(1'b0, 1'b0, 1'b0, 16'h0005, 16'h0000, 1'b0);
      check("rst_mid_word5", 32'(RespData), 32'h0000AB12);

      // Random traffic against the shadow memory
      for (int n = 0; n < 200; n++) begin
         rw = 1'($urandom);
         rb = 1'($urandom);
         rs = 1'($urandom);
         rh = 1'($urandom);
         if ($urandom_range(0, 7) == 0) ra = 16'($urandom);
         else if (rb)                    ra = 16'($urandom_range(0, 511));
         else                            ra = 16'($urandom_range(0, 255));
         doReq(rw, rb, rs, ra, 16'($urandom), rh);
      end

      mism = 0;
      for (int i = 0; i < 256; i++) if (ram[i] !== refMem[i]) mism++;
      check("final_memory", 32'(mism), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
